// File: rtl/edge_pkg.sv
// Shared types and constants for the gradient edge detector.
package edge_pkg;

    typedef enum logic [1:0] {
        SOBEL   = 2'd0,
        PREWITT = 2'd1,
        SCHARR  = 2'd2
    } kernel_e;

    localparam int GRAD_EXTRA   = 6;
    localparam int SCHARR_SHIFT = 2;

    localparam logic [4:0] SOBEL_EDGE   = 5'd1;
    localparam logic [4:0] SOBEL_MID    = 5'd2;
    localparam logic [4:0] PREWITT_EDGE = 5'd1;
    localparam logic [4:0] PREWITT_MID  = 5'd1;
    localparam logic [4:0] SCHARR_EDGE  = 5'd3;
    localparam logic [4:0] SCHARR_MID   = 5'd10;

    // The reserved encoding falls back to Sobel.
    function automatic kernel_e decode_kernel(input logic [1:0] sel);
        kernel_e k;
        case (sel)
            2'd1:    k = PREWITT;
            2'd2:    k = SCHARR;
            default: k = SOBEL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/edge_detector_if.sv
// Pixel stream in and edge stream out; the detector is the slave side.
interface edge_detector_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] pixel_in;
    logic                   valid_in;
    logic                   sof_in;
    logic [PIXEL_WIDTH-1:0] edge_out;
    logic                   valid_out;
    logic                   sof_out;
    logic                   eol_out;

    modport master (
        output pixel_in, valid_in, sof_in,
        input  edge_out, valid_out, sof_out, eol_out
    );

    modport slave (
        input  pixel_in, valid_in, sof_in,
        output edge_out, valid_out, sof_out, eol_out
    );
endinterface

// File: rtl/window3x3_gen.sv
// Raster position tracking, per-frame config shadow, two line buffers and the
// registered 3x3 window (pipeline stage S1) with its qualifying flags.
module window3x3_gen
    import edge_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_WIDTH   = 640
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [PIXEL_WIDTH-1:0]              i_pixel,
    input  logic                                i_valid,
    input  logic                                i_sof,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]      i_cfg_width,
    input  logic [1:0]                          i_cfg_kernel,
    input  logic                                i_cfg_mag_max,
    input  logic                                i_cfg_thresh_en,
    input  logic [PIXEL_WIDTH-1:0]              i_cfg_thresh,
    output logic [2:0][2:0][PIXEL_WIDTH-1:0]    o_win,
    output logic                                o_valid,
    output logic                                o_sof,
    output logic                                o_eol,
    output kernel_e                             o_kernel,
    output logic                                o_mag_max,
    output logic                                o_thresh_en,
    output logic [PIXEL_WIDTH-1:0]              o_thresh
);
    localparam int CW = $clog2(MAX_WIDTH + 1);
    localparam logic [CW-1:0] W_MAX = CW'(MAX_WIDTH);
    localparam logic [CW-1:0] W_MIN = CW'(3);

    logic [CW-1:0]          r_col;
    logic [1:0]             r_row;
    logic [CW-1:0]          r_width;
    kernel_e                r_kernel;
    logic                   r_mag_max;
    logic                   r_thresh_en;
    logic [PIXEL_WIDTH-1:0] r_thresh;
    logic [PIXEL_WIDTH-1:0] r_lb0 [MAX_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_lb1 [MAX_WIDTH];
    logic [2:0][2:0][PIXEL_WIDTH-1:0] r_win;
    logic                   r_valid;
    logic                   r_sof;
    logic                   r_eol;

    logic [CW-1:0] w_col;
    logic [1:0]    w_row;
    logic          w_origin;
    logic [CW-1:0] w_width_cfg;
    logic [CW-1:0] w_width;
    logic          w_last;
    logic          w_qual;
    logic [CW-1:0] w_col_nxt;
    logic [1:0]    w_row_nxt;

    // Position of the pixel on the input this cycle and the counters after it.
    // Row saturates at 3: only row 2 versus row > 2 matters downstream.
    always_comb begin
        w_col    = i_sof ? '0 : r_col;
        w_row    = i_sof ? 2'd0 : r_row;
        w_origin = (w_col == '0) && (w_row == 2'd0);
        if (i_cfg_width < W_MIN) begin
            w_width_cfg = W_MIN;
        end else if (i_cfg_width > W_MAX) begin
            w_width_cfg = W_MAX;
        end else begin
            w_width_cfg = i_cfg_width;
        end
        w_width = w_origin ? w_width_cfg : r_width;
        w_last  = (w_col == (w_width - CW'(1)));
        w_qual  = (w_row >= 2'd2) && (w_col >= CW'(2));
        if (w_last) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == 2'd3) ? 2'd3 : (w_row + 2'd1);
        end else begin
            w_col_nxt = w_col + CW'(1);
            w_row_nxt = w_row;
        end
    end

    // Raster counters advance on accepted pixels only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= 2'd0;
        end else if (i_valid) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // Config shadow reloads only on the pixel accepted at the frame origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_width     <= W_MAX;
            r_kernel    <= SOBEL;
            r_mag_max   <= 1'b0;
            r_thresh_en <= 1'b0;
            r_thresh    <= '0;
        end else if (i_valid && w_origin) begin
            r_width     <= w_width_cfg;
            r_kernel    <= decode_kernel(i_cfg_kernel);
            r_mag_max   <= i_cfg_mag_max;
            r_thresh_en <= i_cfg_thresh_en;
            r_thresh    <= i_cfg_thresh;
        end
    end

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_lb0[w_col] <= i_pixel;
            r_lb1[w_col] <= r_lb0[w_col];
        end
    end

    // Window shifts one column per accepted pixel; flags mark qualifying pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
        end else begin
            if (i_valid) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= r_lb1[w_col];
                r_win[1][2] <= r_lb0[w_col];
                r_win[2][2] <= i_pixel;
            end
            r_valid <= i_valid && w_qual;
            r_sof   <= i_valid && (w_row == 2'd2) && (w_col == CW'(2));
            r_eol   <= i_valid && w_qual && w_last;
        end
    end

    assign o_win       = r_win;
    assign o_valid     = r_valid;
    assign o_sof       = r_sof;
    assign o_eol       = r_eol;
    assign o_kernel    = r_kernel;
    assign o_mag_max   = r_mag_max;
    assign o_thresh_en = r_thresh_en;
    assign o_thresh    = r_thresh;

endmodule

// File: rtl/edge_detector.sv
// Streaming 3x3 gradient edge detector: window (S1) in window3x3_gen,
// gradients (S2) and magnitude/saturation/threshold output (S3) here.
module edge_detector
    import edge_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_WIDTH   = 640
) (
    input  logic                           clk,
    input  logic                           rst_n,
    edge_detector_if.slave                 bus,
    input  logic [$clog2(MAX_WIDTH+1)-1:0] cfg_width,
    input  logic [1:0]                     cfg_kernel,
    input  logic                           cfg_mag_max,
    input  logic                           cfg_thresh_en,
    input  logic [PIXEL_WIDTH-1:0]         cfg_thresh
);
    localparam int GW = PIXEL_WIDTH + GRAD_EXTRA;
    localparam logic [PIXEL_WIDTH-1:0] PIX_MAX = '1;

    logic [2:0][2:0][PIXEL_WIDTH-1:0] w_win;
    logic                   w_s1_valid;
    logic                   w_s1_sof;
    logic                   w_s1_eol;
    kernel_e                w_kernel;
    logic                   w_mag_max;
    logic                   w_thresh_en;
    logic [PIXEL_WIDTH-1:0] w_thresh;

    window3x3_gen #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .MAX_WIDTH   (MAX_WIDTH)
    ) u_window (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_pixel         (bus.pixel_in),
        .i_valid         (bus.valid_in),
        .i_sof           (bus.sof_in),
        .i_cfg_width     (cfg_width),
        .i_cfg_kernel    (cfg_kernel),
        .i_cfg_mag_max   (cfg_mag_max),
        .i_cfg_thresh_en (cfg_thresh_en),
        .i_cfg_thresh    (cfg_thresh),
        .o_win           (w_win),
        .o_valid         (w_s1_valid),
        .o_sof           (w_s1_sof),
        .o_eol           (w_s1_eol),
        .o_kernel        (w_kernel),
        .o_mag_max       (w_mag_max),
        .o_thresh_en     (w_thresh_en),
        .o_thresh        (w_thresh)
    );

    function automatic logic signed [GW-1:0] grad_diff(input logic [PIXEL_WIDTH-1:0] a,
                                                       input logic [PIXEL_WIDTH-1:0] b);
        return $signed({{GRAD_EXTRA{1'b0}}, a}) - $signed({{GRAD_EXTRA{1'b0}}, b});
    endfunction

    logic [4:0]             w_ce;
    logic [4:0]             w_cm;
    logic signed [GW-1:0]   w_gx;
    logic signed [GW-1:0]   w_gy;

    logic signed [GW-1:0]   r_gx;
    logic signed [GW-1:0]   r_gy;
    logic                   r_s2_valid;
    logic                   r_s2_sof;
    logic                   r_s2_eol;
    logic                   r_s2_scharr;
    logic                   r_s2_mag_max;
    logic                   r_s2_thresh_en;
    logic [PIXEL_WIDTH-1:0] r_s2_thresh;

    // S2: gradients with the edge/middle coefficients of the latched kernel.
    always_comb begin
        case (w_kernel)
            PREWITT: begin
                w_ce = PREWITT_EDGE;
                w_cm = PREWITT_MID;
            end
            SCHARR: begin
                w_ce = SCHARR_EDGE;
                w_cm = SCHARR_MID;
            end
            default: begin
                w_ce = SOBEL_EDGE;
                w_cm = SOBEL_MID;
            end
        endcase
        w_gx = $signed(GW'(w_ce)) * grad_diff(w_win[0][2], w_win[0][0])
             + $signed(GW'(w_cm)) * grad_diff(w_win[1][2], w_win[1][0])
             + $signed(GW'(w_ce)) * grad_diff(w_win[2][2], w_win[2][0]);
        w_gy = $signed(GW'(w_ce)) * grad_diff(w_win[2][0], w_win[0][0])
             + $signed(GW'(w_cm)) * grad_diff(w_win[2][1], w_win[0][1])
             + $signed(GW'(w_ce)) * grad_diff(w_win[2][2], w_win[0][2]);
    end

    // S2 register; config travels with the data so in-flight results survive a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gx           <= '0;
            r_gy           <= '0;
            r_s2_valid     <= 1'b0;
            r_s2_sof       <= 1'b0;
            r_s2_eol       <= 1'b0;
            r_s2_scharr    <= 1'b0;
            r_s2_mag_max   <= 1'b0;
            r_s2_thresh_en <= 1'b0;
            r_s2_thresh    <= '0;
        end else begin
            r_gx           <= w_gx;
            r_gy           <= w_gy;
            r_s2_valid     <= w_s1_valid;
            r_s2_sof       <= w_s1_sof;
            r_s2_eol       <= w_s1_eol;
            r_s2_scharr    <= (w_kernel == SCHARR);
            r_s2_mag_max   <= w_mag_max;
            r_s2_thresh_en <= w_thresh_en;
            r_s2_thresh    <= w_thresh;
        end
    end

    logic [GW-1:0]          w_ax;
    logic [GW-1:0]          w_ay;
    logic [GW-1:0]          w_mag_raw;
    logic [GW-1:0]          w_mag;
    logic [PIXEL_WIDTH-1:0] w_sat;
    logic [PIXEL_WIDTH-1:0] w_edge;

    // S3: magnitude, Scharr normalisation, saturation and optional binarisation.
    always_comb begin
        w_ax = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
        w_ay = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
        if (r_s2_mag_max) begin
            w_mag_raw = (w_ax > w_ay) ? w_ax : w_ay;
        end else begin
            w_mag_raw = w_ax + w_ay;
        end
        w_mag = r_s2_scharr ? (w_mag_raw >> SCHARR_SHIFT) : w_mag_raw;
        if (w_mag > {{GRAD_EXTRA{1'b0}}, PIX_MAX}) begin
            w_sat = PIX_MAX;
        end else begin
            w_sat = w_mag[PIXEL_WIDTH-1:0];
        end
        if (r_s2_thresh_en) begin
            w_edge = (w_sat >= r_s2_thresh) ? PIX_MAX : '0;
        end else begin
            w_edge = w_sat;
        end
    end

    logic [PIXEL_WIDTH-1:0] r_edge;
    logic                   r_valid_out;
    logic                   r_sof_out;
    logic                   r_eol_out;

    // Output registers; edge value holds between valid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge      <= '0;
            r_valid_out <= 1'b0;
            r_sof_out   <= 1'b0;
            r_eol_out   <= 1'b0;
        end else begin
            r_valid_out <= r_s2_valid;
            r_sof_out   <= r_s2_valid && r_s2_sof;
            r_eol_out   <= r_s2_valid && r_s2_eol;
            if (r_s2_valid) begin
                r_edge <= w_edge;
            end
        end
    end

    assign bus.edge_out  = r_edge;
    assign bus.valid_out = r_valid_out;
    assign bus.sof_out   = r_sof_out;
    assign bus.eol_out   = r_eol_out;

endmodule

// File: tb/tb_edge_detector.sv
// Directed-frame bench: stimulus pushes hand-derived results into a scoreboard,
// a monitor pops and compares value, markers and arrival cycle.
module tb_edge_detector;
    localparam int P    = 8;
    localparam int MAXW = 640;
    localparam int CW   = $clog2(MAXW + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] cfg_width;
    logic [1:0]    cfg_kernel;
    logic          cfg_mag_max;
    logic          cfg_thresh_en;
    logic [P-1:0]  cfg_thresh;

    edge_detector_if #(.PIXEL_WIDTH(P)) u_if ();

    edge_detector #(.PIXEL_WIDTH(P), .MAX_WIDTH(MAXW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (u_if),
        .cfg_width     (cfg_width),
        .cfg_kernel    (cfg_kernel),
        .cfg_mag_max   (cfg_mag_max),
        .cfg_thresh_en (cfg_thresh_en),
        .cfg_thresh    (cfg_thresh)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    edge_v;
        bit    sof;
        bit    eol;
        int    cyc;
        string name;
    } exp_t;

    exp_t  sb[$];
    int    cyc       = 0;
    int    n_cmp     = 0;
    int    n_bad     = 0;
    int    last_edge = 0;
    string cur       = "reset";

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge either a scoreboard beat or an idle/hold check.
    initial begin
        forever begin
            @(negedge clk);
            if (u_if.valid_out === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got valid_out edge=%0d at cycle %0d, required no output",
                             u_if.edge_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (u_if.edge_out !== P'(e.edge_v) || u_if.sof_out !== e.sof ||
                        u_if.eol_out !== e.eol || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL %s: got edge=%0d sof=%0b eol=%0b cycle=%0d, required edge=%0d sof=%0b eol=%0b cycle=%0d",
                                 e.name, u_if.edge_out, u_if.sof_out, u_if.eol_out, cyc,
                                 e.edge_v, e.sof, e.eol, e.cyc);
                    end
                    last_edge = e.edge_v;
                end
            end else begin
                n_cmp++;
                if (u_if.sof_out !== 1'b0 || u_if.eol_out !== 1'b0 || u_if.edge_out !== P'(last_edge)) begin
                    n_bad++;
                    $display("FAIL idle_hold: got edge=%0d sof=%0b eol=%0b, required edge=%0d sof=0 eol=0",
                             u_if.edge_out, u_if.sof_out, u_if.eol_out, last_edge);
                end
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    exp_t m;
                    m = sb.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s_missing: got no valid_out at cycle %0d, required edge=%0d at cycle %0d",
                             m.name, cyc, m.edge_v, m.cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    // Vertical step frame: columns >= step carry hi. Centres step-1 and step
    // straddle the step and give exp_step; every other centre is flat (0).
    task automatic send_frame(input int w, input int cfgw, input int h, input int step,
                              input int hi, input int exp_step, input bit use_sof,
                              input int abort_n, input bit gaps, input int mid_w);
        int idx;
        idx = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (abort_n >= 0 && idx == abort_n) return;
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clk);
                        u_if.valid_in = 1'b0;
                        u_if.sof_in   = 1'b1;
                        u_if.pixel_in = P'($urandom);
                    end
                end
                @(negedge clk);
                if (idx == 0) cfg_width = CW'(cfgw);
                if (mid_w > 0 && idx == 2 * w) cfg_width = CW'(mid_w);
                u_if.valid_in = 1'b1;
                u_if.sof_in   = (idx == 0) && use_sof;
                u_if.pixel_in = (c >= step) ? P'(hi) : '0;
                if (r >= 2 && c >= 2) begin
                    exp_t e;
                    e.edge_v = ((c - 1 == step - 1) || (c - 1 == step)) ? exp_step : 0;
                    e.sof    = (r == 2) && (c == 2);
                    e.eol    = (c == w - 1);
                    e.cyc    = cyc + 3;
                    e.name   = cur;
                    sb.push_back(e);
                end
                idx++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            u_if.valid_in = 1'b0;
            u_if.sof_in   = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        idle(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d results outstanding, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_edge"},  32'(u_if.edge_out),  32'd0);
        check({nm, "_valid"}, 32'(u_if.valid_out), 32'd0);
        check({nm, "_sof"},   32'(u_if.sof_out),   32'd0);
        check({nm, "_eol"},   32'(u_if.eol_out),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required self-termination");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        u_if.valid_in = 1'b0;
        u_if.sof_in   = 1'b0;
        u_if.pixel_in = '0;
        cfg_width     = CW'(5);
        cfg_kernel    = 2'd0;
        cfg_mag_max   = 1'b0;
        cfg_thresh_en = 1'b0;
        cfg_thresh    = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted while (3,3) and (3,4) are still in the pipeline.
        cur = "rst_mid";
        send_frame(5, 5, 5, 2, 100, 255, 1'b1, 20, 1'b0, 0);
        @(negedge clk);
        u_if.valid_in = 1'b0;
        u_if.sof_in   = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_edge = 0;
        #1;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First pixel after reset is the origin even without sof_in: 9 outputs.
        cur = "post_rst";
        send_frame(5, 5, 5, 2, 100, 255, 1'b0, -1, 1'b0, 0);
        drain(cur);

        // Back-to-back frames, one per kernel/mode; 800 saturates to 255.
        cur = "sobel_l1";
        send_frame(8, 8, 4, 4, 200, 255, 1'b1, -1, 1'b0, 0);
        cur = "scharr_max";
        cfg_kernel  = 2'd2;
        cfg_mag_max = 1'b1;
        send_frame(8, 8, 4, 4, 10, 40, 1'b1, -1, 1'b0, 0);
        cur = "prewitt_l1";
        cfg_kernel  = 2'd1;
        cfg_mag_max = 1'b0;
        send_frame(8, 8, 4, 4, 10, 30, 1'b1, -1, 1'b0, 0);
        cur = "thresh_hit";
        cfg_kernel    = 2'd0;
        cfg_thresh_en = 1'b1;
        cfg_thresh    = P'(40);
        send_frame(8, 8, 4, 4, 10, 255, 1'b1, -1, 1'b0, 0);
        cur = "thresh_miss";
        send_frame(8, 8, 4, 4, 9, 0, 1'b1, -1, 1'b0, 0);
        drain(cur);
        cfg_thresh_en = 1'b0;

        // Width 2 clamps to 3: a 3x3 frame gives one output with sof and eol.
        cur = "clamp_w3";
        send_frame(3, 2, 3, 1, 50, 200, 1'b1, -1, 1'b0, 0);
        drain(cur);

        // Width change mid-frame waits for the next sof; random gaps throughout.
        cur = "width8_gaps";
        send_frame(8, 8, 4, 4, 200, 255, 1'b1, -1, 1'b1, 5);
        cur = "width5_gaps";
        send_frame(5, 5, 4, 2, 200, 255, 1'b1, -1, 1'b1, 0);
        drain(cur);

        // Early sof at (3,4); old results (reserved kernel = Sobel) still emerge.
        cur = "early_old";
        cfg_kernel = 2'd3;
        send_frame(6, 6, 6, 3, 200, 255, 1'b1, 22, 1'b0, 0);
        cur = "early_new";
        cfg_kernel = 2'd1;
        send_frame(6, 6, 6, 3, 10, 30, 1'b1, -1, 1'b0, 0);
        drain(cur);

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
